// File: rtl/chip8_pkg.sv
// Shared constants, bus types and helpers for the CHIP-8 VGA scanout.
package chip8_pkg;

   localparam int unsigned FB_W    = 64;
   localparam int unsigned FB_H    = 32;
   localparam int unsigned FB_BITS = FB_W * FB_H;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;

   localparam int unsigned H_CNT_W = 10;
   localparam int unsigned V_CNT_W = 10;
   localparam int unsigned RGB_W   = 12;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_active;
      logic vblank;
      logic frame_start;
   } vga_timing_t;

   // Bit offset of framebuffer row y inside the display vector.
   function automatic int unsigned row_base(input int unsigned y);
      return (FB_H - 1 - y) * FB_W;
   endfunction

endpackage

// File: rtl/chip8_vga_timing.sv
// Pixel prescaler, raster counters and registered sync/blanking flags.
module chip8_vga_timing
   import chip8_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP
) (
   input  logic               clk,
   input  logic               rst,
   output logic               pix_tick_c,
   output logic [H_CNT_W-1:0] h_count,
   output logic [V_CNT_W-1:0] v_count,
   output vga_timing_t        timing
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam vga_timing_t TIMING_RST = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};

   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [H_CNT_W-1:0] h_q, h_d;
   logic [V_CNT_W-1:0] v_q, v_d;
   vga_timing_t        tm_q, tm_d;
   logic               h_last, v_last;

   // Flags describe the position held before this tick's increment.
   always_comb begin
      pix_tick_c = (CLK_DIV == 1) || (pre_q == PRE_W'(CLK_DIV - 1));
      h_last     = (h_q == H_CNT_W'(H_TOTAL - 1));
      v_last     = (v_q == V_CNT_W'(V_TOTAL - 1));
      pre_d      = pix_tick_c ? '0 : pre_q + PRE_W'(1);
      h_d        = h_q;
      v_d        = v_q;
      tm_d       = tm_q;
      tm_d.frame_start = 1'b0;
      if (pix_tick_c) begin
         h_d = h_last ? '0 : h_q + H_CNT_W'(1);
         if (h_last) begin
            v_d = v_last ? '0 : v_q + V_CNT_W'(1);
         end
         tm_d.hsync        = !((h_q >= H_CNT_W'(HS_START)) && (h_q < H_CNT_W'(HS_END)));
         tm_d.vsync        = !((v_q >= V_CNT_W'(VS_START)) && (v_q < V_CNT_W'(VS_END)));
         tm_d.video_active = (h_q < H_CNT_W'(H_ACTIVE)) && (v_q < V_CNT_W'(V_ACTIVE));
         tm_d.vblank       = (v_q >= V_CNT_W'(V_ACTIVE));
         tm_d.frame_start  = (h_q == '0) && (v_q == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
         tm_q  <= TIMING_RST;
      end else begin
         pre_q <= pre_d;
         h_q   <= h_d;
         v_q   <= v_d;
         tm_q  <= tm_d;
      end
   end

   assign h_count = h_q;
   assign v_count = v_q;
   assign timing  = tm_q;

endmodule

// File: rtl/chip8_vga_scanout.sv
// CHIP-8 framebuffer reader: scales 64x32 to the VGA raster with a per-line row latch.
module chip8_vga_scanout
   import chip8_pkg::*;
#(
   parameter int unsigned     CLK_DIV  = 4,
   parameter int unsigned     SCALE    = 10,
   parameter int unsigned     V_OFFSET = 80,
   parameter int unsigned     H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned     H_FP     = VGA_H_FP,
   parameter int unsigned     H_SYNC   = VGA_H_SYNC,
   parameter int unsigned     H_BP     = VGA_H_BP,
   parameter int unsigned     V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned     V_FP     = VGA_V_FP,
   parameter int unsigned     V_SYNC   = VGA_V_SYNC,
   parameter int unsigned     V_BP     = VGA_V_BP,
   parameter logic [RGB_W-1:0] FG_RGB  = 12'hFFF,
   parameter logic [RGB_W-1:0] BG_RGB  = 12'h000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FB_BITS-1:0] display_in,
   output logic               hsync,
   output logic               vsync,
   output logic               video_active,
   output logic               pixel_on,
   output logic [RGB_W-1:0]   rgb,
   output logic               vblank,
   output logic               frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned WIN_END = V_OFFSET + FB_H * SCALE;
   localparam int unsigned SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int unsigned COL_W   = $clog2(FB_W);
   localparam int unsigned ROW_W   = $clog2(FB_H);

   logic               pix_tick_c;
   logic [H_CNT_W-1:0] h_count;
   logic [V_CNT_W-1:0] v_count;
   vga_timing_t        timing;

   chip8_vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk       (clk),
      .rst       (rst),
      .pix_tick_c(pix_tick_c),
      .h_count   (h_count),
      .v_count   (v_count),
      .timing    (timing)
   );

   logic [SUB_W-1:0]   sub_x_q, sub_x_d, sub_y_q, sub_y_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [FB_W-1:0]    row_latch_q, row_latch_d;
   logic               pixel_on_q, pixel_on_d;
   logic [RGB_W-1:0]   rgb_q, rgb_d;
   logic               h_last, v_last, in_win, next_in_win, active;
   logic [V_CNT_W-1:0] v_next;

   always_comb begin
      h_last      = (h_count == H_CNT_W'(H_TOTAL - 1));
      v_last      = (v_count == V_CNT_W'(V_TOTAL - 1));
      v_next      = v_last ? '0 : v_count + V_CNT_W'(1);
      in_win      = (v_count >= V_CNT_W'(V_OFFSET)) && (v_count < V_CNT_W'(WIN_END));
      next_in_win = (v_next >= V_CNT_W'(V_OFFSET)) && (v_next < V_CNT_W'(WIN_END));
      active      = (h_count < H_CNT_W'(H_ACTIVE)) && (v_count < V_CNT_W'(V_ACTIVE));
      sub_x_d     = sub_x_q;
      col_d       = col_q;
      sub_y_d     = sub_y_q;
      row_d       = row_q;
      row_latch_d = row_latch_q;
      pixel_on_d  = pixel_on_q;
      rgb_d       = rgb_q;
      if (pix_tick_c) begin
         // Column walk keeps counting through blanking; h_last re-aligns it.
         if (h_last) begin
            sub_x_d = '0;
            col_d   = '0;
         end else if (sub_x_q == SUB_W'(SCALE - 1)) begin
            sub_x_d = '0;
            col_d   = col_q + COL_W'(1);
         end else begin
            sub_x_d = sub_x_q + SUB_W'(1);
         end
         if (h_last) begin
            if (v_last) begin
               sub_y_d = '0;
               row_d   = '0;
            end else if (in_win) begin
               if (sub_y_q == SUB_W'(SCALE - 1)) begin
                  sub_y_d = '0;
                  row_d   = row_q + ROW_W'(1);
               end else begin
                  sub_y_d = sub_y_q + SUB_W'(1);
               end
            end
            if (next_in_win) begin
               row_latch_d = display_in[row_base(32'(row_d)) +: FB_W];
            end
         end
         pixel_on_d = active && in_win && row_latch_q[col_q];
         rgb_d      = pixel_on_d ? FG_RGB : (active ? BG_RGB : '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_x_q     <= '0;
         col_q       <= '0;
         sub_y_q     <= '0;
         row_q       <= '0;
         row_latch_q <= '0;
         pixel_on_q  <= 1'b0;
         rgb_q       <= '0;
      end else begin
         sub_x_q     <= sub_x_d;
         col_q       <= col_d;
         sub_y_q     <= sub_y_d;
         row_q       <= row_d;
         row_latch_q <= row_latch_d;
         pixel_on_q  <= pixel_on_d;
         rgb_q       <= rgb_d;
      end
   end

   assign hsync        = timing.hsync;
   assign vsync        = timing.vsync;
   assign video_active = timing.video_active;
   assign vblank       = timing.vblank;
   assign frame_start  = timing.frame_start;
   assign pixel_on     = pixel_on_q;
   assign rgb          = rgb_q;

endmodule

// File: tb/tb_chip8_vga_scanout.sv
// Bench for chip8_vga_scanout: two instances (1 and 4 clks per pixel) on a reduced
// raster, each scored tick by tick against an independent division-based model.
module tb_chip8_vga_scanout;

   localparam int SC   = 2;
   localparam int VOFF = 8;
   localparam int HA = 128, HFP = 4, HSY = 8, HBP = 4, HT = HA + HFP + HSY + HBP;
   localparam int VA = 80,  VFP = 2, VSY = 2, VBP = 3, VT = VA + VFP + VSY + VBP;
   localparam logic [11:0] FG = 12'hFFF;
   localparam logic [11:0] BG = 12'h00A;

   typedef logic [17:0]   obs_t;   // {fs, vblank, hsync, vsync, active, pixel_on, rgb}
   typedef logic [2047:0] fb_t;
   localparam obs_t RST_OBS = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000};

   logic clk = 1'b0;
   logic rst;
   fb_t  display_in;
   logic hsync0, vsync0, act0, pon0, vb0, fs0;
   logic hsync1, vsync1, act1, pon1, vb1, fs1;
   logic [11:0] rgb0, rgb1;

   always #5 clk = ~clk;

   chip8_vga_scanout #(
      .CLK_DIV(1), .SCALE(SC), .V_OFFSET(VOFF),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .FG_RGB(FG), .BG_RGB(BG)
   ) dut0 (
      .clk(clk), .rst(rst), .display_in(display_in),
      .hsync(hsync0), .vsync(vsync0), .video_active(act0), .pixel_on(pon0),
      .rgb(rgb0), .vblank(vb0), .frame_start(fs0)
   );

   chip8_vga_scanout #(
      .CLK_DIV(4), .SCALE(SC), .V_OFFSET(VOFF),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .FG_RGB(FG), .BG_RGB(BG)
   ) dut1 (
      .clk(clk), .rst(rst), .display_in(display_in),
      .hsync(hsync1), .vsync(vsync1), .video_active(act1), .pixel_on(pon1),
      .rgb(rgb1), .vblank(vb1), .frame_start(fs1)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   pre[2], mh[2], mv[2], last_fs[2];
   bit   tick[2], first_pend[2];
   fb_t  snap[2];
   obs_t cur[2];
   obs_t sb[2][$];
   int   ncyc = 0, rel_cyc = 0, nfs = 0, fg_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
      end
   endtask

   function automatic int div_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic obs_t obs(input int k);
      if (k == 0) return {fs0, vb0, hsync0, vsync0, act0, pon0, rgb0};
      return {fs1, vb1, hsync1, vsync1, act1, pon1, rgb1};
   endfunction

   function automatic fb_t px(input int x, input int y);
      fb_t f = '0;
      f[(31 - y) * 64 + x] = 1'b1;
      return f;
   endfunction

   task automatic fill_random(output fb_t f);
      for (int i = 0; i < 64; i++) f[i*32 +: 32] = $urandom;
   endtask

   // Expected outputs for the raster position the model currently holds.
   function automatic obs_t expect_at(input int k);
      int   h = mh[k];
      int   v = mv[k];
      logic hs, vs, va, win, pon, vb, fs;
      logic [11:0] c;
      hs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
      vs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      va  = (h < HA) && (v < VA);
      win = (v >= VOFF) && (v < VOFF + 32 * SC);
      vb  = (v >= VA);
      fs  = (h == 0) && (v == 0);
      pon = 1'b0;
      if (va && win) pon = snap[k][(31 - (v - VOFF) / SC) * 64 + h / SC];
      c = pon ? FG : (va ? BG : 12'h000);
      return {fs, vb, hs, vs, va, pon, c};
   endfunction

   task automatic step(input int k);
      int nv;
      if (rst) begin
         pre[k] = 0; mh[k] = 0; mv[k] = 0; snap[k] = '0;
         tick[k] = 1'b0; cur[k] = RST_OBS; sb[k].delete();
      end else begin
         tick[k] = (pre[k] == div_of(k) - 1);
         pre[k]  = tick[k] ? 0 : pre[k] + 1;
         if (tick[k]) begin
            sb[k].push_back(expect_at(k));
            if (mh[k] == HT - 1) begin
               nv = (mv[k] == VT - 1) ? 0 : mv[k] + 1;
               if (nv >= VOFF && nv < VOFF + 32 * SC) snap[k] = display_in;
               mv[k] = nv;
               mh[k] = 0;
            end else begin
               mh[k] = mh[k] + 1;
            end
         end
      end
   endtask

   task automatic cycle();
      obs_t o;
      @(posedge clk);
      for (int k = 0; k < 2; k++) step(k);
      @(negedge clk);
      ncyc++;
      for (int k = 0; k < 2; k++) begin
         if (tick[k] && sb[k].size() > 0) cur[k] = sb[k].pop_front();
         else cur[k][17] = 1'b0;
         o = obs(k);
         check_eq(k == 0 ? "out_div1" : "out_div4", 32'(o), 32'(cur[k]));
         if (o[17]) begin
            if (first_pend[k]) begin
               check_eq(k == 0 ? "fs_first_div1" : "fs_first_div4", ncyc - rel_cyc, div_of(k));
               first_pend[k] = 1'b0;
            end else begin
               check_eq(k == 0 ? "fs_period_div1" : "fs_period_div4",
                        ncyc - last_fs[k], div_of(k) * HT * VT);
            end
            last_fs[k] = ncyc;
         end
      end
      if (fs0) begin
         if (nfs == 1 || nfs == 2) check_eq("fg_cnt", fg_cnt, SC * SC);
         nfs++;
         fg_cnt = 0;
      end
      if (act0 && rgb0 == FG) fg_cnt++;
   endtask

   initial begin
      int  nfs_seen = 0;
      bit  flipped  = 1'b0;
      bit  rst_hit  = 1'b0;
      rst        = 1'b1;
      display_in = px(0, 0);
      for (int k = 0; k < 2; k++) first_pend[k] = 1'b1;
      repeat (3) cycle();
      check_eq("reset_div1", 32'(obs(0)), 32'(RST_OBS));
      check_eq("reset_div4", 32'(obs(1)), 32'(RST_OBS));
      rst     = 1'b0;
      rel_cyc = ncyc;

      for (int i = 0; i < 60000 && !rst_hit; i++) begin
         cycle();
         if (nfs != nfs_seen) begin
            nfs_seen = nfs;
            case (nfs)
               2: display_in = px(63, 31);
               3: fill_random(display_in);
               4: fill_random(display_in);
               5: display_in = '1;
               default: ;
            endcase
         end
         // Mid-line rewrite: line 8 must keep its latched row, line 9 picks this up.
         if (nfs == 3 && !flipped && mh[0] == 65 && mv[0] == 8) begin
            fill_random(display_in);
            flipped = 1'b1;
         end
         if (nfs == 5 && mh[0] == 61 && mv[0] == 40) rst_hit = 1'b1;
      end
      check_eq("flip_done", 32'(flipped), 1);
      check_eq("reset_point_reached", 32'(rst_hit), 1);

      check_eq("pre_rst_pixel_on", 32'(pon0), 1);
      rst = 1'b1;
      #1;
      check_eq("async_rst_div1", 32'(obs(0)), 32'(RST_OBS));
      check_eq("async_rst_div4", 32'(obs(1)), 32'(RST_OBS));
      repeat (3) cycle();
      rst     = 1'b0;
      rel_cyc = ncyc;
      for (int k = 0; k < 2; k++) first_pend[k] = 1'b1;
      repeat (HT * VT + 72) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/chip8_vga_scanout.md
Name: chip8_vga_scanout

Overview:
- Reader side of the CHIP-8 framebuffer. The sprite draw path writes the 2048-bit display vector; this block reads it.
- Generates 640x480@60 VGA timing and scales each of the 64x32 pixels to a SCALE x SCALE block.
- The 640x320 image is centred vertically, with background-colour borders top and bottom.
- Snapshots one 64-bit framebuffer row per scaled line, so a draw cannot tear a line mid-scan. Provides a vblank flag and a frame_start pulse so the CPU can pace its draws.

Parameters:
- CLK_DIV, 4: system clocks per pixel. 1 means one pixel per clk. 4 gives 25 MHz pixels from 100 MHz.
- SCALE, 10: screen pixels per CHIP-8 pixel, both axes.
- V_OFFSET, 80: first active line of the image, equal to (480 - 32*SCALE)/2.
- H_ACTIVE, H_FP, H_SYNC, H_BP: 640, 16, 96, 48. H_TOTAL is 800.
- V_ACTIVE, V_FP, V_SYNC, V_BP: 480, 10, 2, 33. V_TOTAL is 525.
- FG_RGB, 12'hFFF: colour of a lit pixel.
- BG_RGB, 12'h000: colour of an unlit pixel and the border.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- display_in  in  2048  framebuffer; pixel (x,y) is bit (31-y)*64 + x
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_active  out  1  high inside the 640x480 visible area
- pixel_on  out  1  current screen pixel is a lit CHIP-8 pixel
- rgb  out  12  4:4:4 colour; zero outside video_active
- vblank  out  1  high while v_count >= V_ACTIVE
- frame_start  out  1  one-clk pulse at the tick where h=0, v=0

Behaviour:
Reset
- Asynchronous. All counters and the prescaler clear to 0.
- hsync=1, vsync=1, video_active=0, pixel_on=0, rgb=0, vblank=0, frame_start=0.
- The row latch clears to 0.
- Reset mid-frame restarts timing at h=0, v=0. The first frame_start follows the first pix_tick after reset deasserts.

Pixel tick
- A prescaler counts 0..CLK_DIV-1. pix_tick is high when the prescaler is at CLK_DIV-1, or on every clk when CLK_DIV=1.
- All counters and outputs change only on clk edges where pix_tick is high.

Counters
- h_count runs 0..H_TOTAL-1.
- v_count runs 0..V_TOTAL-1 and increments when h_count wraps.

Registered outputs
- Outputs are registered and describe the (h,v) position held before that tick's increment: one tick of latency, with all outputs mutually aligned.
- hsync=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync=0 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- video_active = (h < H_ACTIVE) and (v < V_ACTIVE).
- frame_start is high for exactly one clk, the clk whose tick emits h=0, v=0.

Image window and sub-counters
- The image window is v in [V_OFFSET, V_OFFSET+32*SCALE), all 640 columns.
- No dividers are used. Each axis has a sub-counter 0..SCALE-1 and a cell counter: col 0..63 and row 0..31.
- col and sub_x reset to 0 at h=0 and advance across the active line. col wraps 63->0 at the H_ACTIVE boundary; it is unused in blanking.
- row and sub_y reset to 0 when v wraps to 0. They advance only on line ends where v is inside the image window.

Row latch
- On the tick with h=H_TOTAL-1, the latch loads the row that line v+1 will display: display_in[(31-row_next)*64 +: 64].
- The latch loads only if line v+1 is inside the image window. Otherwise it holds its value.
- display_in is sampled only at this instant. Changes during the line are not visible until the next latch.

Pixel colour
- pixel_on = video_active AND inside image window AND row_latch[col].
- rgb = FG_RGB when pixel_on.
- rgb = BG_RGB when video_active and not pixel_on.
- rgb = 0 otherwise.

Wrap-around
- v=V_TOTAL-1 with h=H_TOTAL-1 wraps both counters to 0 on the same tick.
- If V_OFFSET is 0, row 0 is latched at that same tick.

Decomposition:
- chip8_pkg holds FB_W=64, FB_H=32, FB_BITS=2048, a row_base(y) function returning (31-y)*64, and the VGA 640x480 timing constants.
- Sub-module chip8_vga_timing holds the prescaler, h/v counters, sync, video_active, vblank and frame_start.
- The top level adds the scale counters, the row latch and the colour mux.

Test Plan:
- Reset then release, CLK_DIV=1 -> frame_start after 1 tick. The next frame_start follows exactly 800*525=420000 clks later. hsync low 96 ticks starting at h=656. vsync low 2 lines starting at v=490.
- display_in with only bit 31*64+0 set (pixel 0,0) -> rgb=FG for h 0..9 on lines v 80..89. rgb=BG everywhere else that is active.
- Pixel (63,31), bit 63 -> FG at h 630..639 on lines v 390..399. Lines 400..479 are all BG.
- Flip display_in mid-line at h=300, v=85 -> line 85 is unchanged. Line 86 shows the new data.
- CLK_DIV=4 -> outputs hold steady 4 clks per pixel. frame_start is exactly 1 clk wide. The frame period is 1680000 clks.
- Assert rst at v=200, h=400 -> outputs are at reset values immediately, without waiting for clk. After release, timing restarts at h=0, v=0.
